uart_fifo_core: RTL
===================

Name: uart_fifo_core

Overview:
Parametrised UART transceiver with internal TX and RX FIFOs. It is the next-generation serial engine between the terminal buffer logic and the PMOD pins. It replaces the bare single-byte rx/tx pair with a valid/ready byte interface, configurable baud, width and depth, and framing and overrun reporting. One instance per serial channel.

Parameters:
CLK_FREQ, 12000000, system clock in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD, truncated (104 at defaults)
DATA_BITS, 8, payload bits per frame, legal range 5..9
FIFO_DEPTH, 16, entries per FIFO, power of two, minimum 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset, sampled on rising clk
tx_data  in  DATA_BITS  byte to transmit
tx_valid  in  1  tx_data is valid
tx_ready  out  1  TX FIFO not full
rx_data  out  DATA_BITS  head of RX FIFO
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  consumer pops RX head
serial_rx  in  1  line input, asynchronous
serial_tx  out  1  line output, idle high
tx_active  out  1  high while a frame is on the line
rx_overrun  out  1  one-cycle pulse: received frame dropped because RX FIFO was full
framing_err  out  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset (rst==0 at a clk edge) sets:
  - serial_tx=1, tx_active=0, rx_valid=0, tx_ready=1, rx_overrun=0, framing_err=0
  - both FIFOs empty
  - both FSMs to IDLE
  - rx_data=0
- Reset mid-frame aborts immediately. serial_tx returns high the cycle after reset is sampled, and any partial RX frame is discarded.
- FIFOs:
  - Circular buffers with log2(FIFO_DEPTH)+1-bit pointers. Full = MSBs differ and the rest are equal. Empty = pointers equal. Pointers wrap naturally.
  - Push on valid&&ready. Pop on rx_valid&&rx_ready (RX FIFO) or on TX FSM load (TX FIFO).
  - rx_data is combinationally the head entry (show-ahead). It is stable while rx_valid=1 and no pop occurs.
  - Simultaneous push and pop while full: both occur and the count is unchanged. tx_ready reflects the registered count, so no push is accepted when full.
  - Simultaneous push and pop while empty: only the push occurs.
- TX FSM:
  - States IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: when the TX FIFO is non-empty, pop the head into a shift register and go to START; tx_active goes high the same edge.
  - START: drive 0 for CLKS_PER_BIT cycles.
  - DATA: drive the bits LSB-first, CLKS_PER_BIT cycles each.
  - STOP: drive 1 for CLKS_PER_BIT cycles, then IDLE with tx_active=0.
  - Back-to-back bytes: if the FIFO is non-empty at the end of STOP, go directly to START with no idle gap, and tx_active stays high.
  - Latency: first start-bit edge on serial_tx appears 2 clk after the tx_valid/tx_ready handshake on an idle channel.
- RX path:
  - serial_rx passes through a 2-FF synchroniser.
  - FSM states IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: a synchronised low moves to START.
  - START: sample at CLKS_PER_BIT/2. If high, it is a glitch and returns to IDLE with no error. If low, go to DATA.
  - DATA: sample each bit at mid-bit, shifted in LSB-first.
  - STOP: sample at mid-bit.
    - Stop=1 and FIFO not full: push the byte.
    - Stop=1 and FIFO full: drop the byte and pulse rx_overrun; FIFO contents are untouched.
    - Stop=0: pulse framing_err and do not push.
  - Return to IDLE right after the stop-bit sample, at mid-stop, so the next start bit is caught.
  - A pop in the same cycle as a push to a full FIFO counts as not-full, so no overrun occurs.
- Counters: the baud counter width is clog2(CLKS_PER_BIT). It reloads on every state transition.

Optional Feature:
Macro UART_FIFO_PARITY_EN.
- Defined: an even-parity bit is inserted after DATA on TX. The XOR of the data bits makes the total count of ones even. RX checks parity at mid-bit. On mismatch the byte is still pushed, and a parity_err output port (1 bit, one-cycle pulse) is asserted at the stop-sample cycle. A frame is 11 bit-times at DATA_BITS=8.
- Undefined: PARITY states and the parity_err port do not exist. A frame is 10 bit-times at DATA_BITS=8.

Test Plan:
1. Reset hold: rst=0 for 5 cycles while toggling tx_valid -> serial_tx=1, tx_ready=1, rx_valid=0, no pulses. After release, no TX activity.
2. Single TX: push 0xA5 -> line shows 0 then 1,0,1,0,0,1,0,1 then 1, each 104±0 cycles. tx_active high for exactly 1040 cycles.
3. Burst and full: push 17 bytes 0x00..0x10 back-to-back on an idle channel.
   - The first byte is popped into the shifter, so all 17 are accepted.
   - An 18th push sees tx_ready=0.
   - Frames are contiguous with no gap, and bytes arrive in order on loopback.
4. RX loopback with overrun: tie serial_tx to serial_rx, hold rx_ready=0, and send 17 bytes.
   - The first 16 are stored.
   - The 17th pulses rx_overrun once.
   - Draining yields 0x00..0x0F in order.
5. Framing error: drive a frame with data 0x3C and stop bit 0 -> framing_err pulses once, rx_valid stays 0. A following valid 0x55 frame is received correctly.
6. Glitch and reset mid-frame: a 30-cycle low pulse on serial_rx -> no push, no error. Assert rst mid-TX at bit 4 -> serial_tx=1 the next cycle, and the FIFO is empty after release.

Source files
------------

// File: rtl/uart_fifo_core.sv
// UART transceiver with show-ahead TX/RX FIFOs; even parity via UART_FIFO_PARITY_EN.
// Latency: start bit leaves 2 clk after the tx handshake; rx_valid rises 1 clk after the mid-stop sample.
// Backpressure: tx_ready drops when the TX FIFO is full; a frame arriving at a full RX FIFO is dropped with rx_overrun.

module uart_fifo_core_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_en,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A same-cycle pop frees the slot being written, so push is allowed even when full.
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign rd_dat  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
    end
endmodule

module uart_fifo_core #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    input  logic                 serial_rx,
    output logic                 serial_tx,
    output logic                 tx_active,
    output logic                 rx_overrun,
`ifdef UART_FIFO_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 framing_err
);
    localparam int CPB   = CLK_FREQ / BAUD;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_FIFO_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic                 tx_empty, tx_full, tx_pop;
    logic [DATA_BITS-1:0] tx_head;
    logic                 rx_empty, rx_full, rx_push, rx_pop;

    uart_fifo_core_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .wr_en(tx_valid && tx_ready), .wr_dat(tx_data),
        .rd_en(tx_pop), .rd_dat(tx_head),
        .full(tx_full), .empty(tx_empty)
    );

    logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d;

    uart_fifo_core_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .wr_en(rx_push), .wr_dat(rx_shreg_q),
        .rd_en(rx_pop), .rd_dat(rx_data),
        .full(rx_full), .empty(rx_empty)
    );

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;

    // ---------------- transmitter ----------------
    state_t               tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
    logic                 serial_tx_q, serial_tx_d;
    logic                 tx_active_q, tx_active_d;
    logic                 tx_bit_done;
`ifdef UART_FIFO_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q + 1'b1;
        tx_bit_d    = tx_bit_q;
        tx_shreg_d  = tx_shreg_q;
        tx_pop      = 1'b0;
        tx_bit_done = (tx_cnt_q == CNT_LAST);
`ifdef UART_FIFO_PARITY_EN
        tx_par_d    = tx_par_q;
`endif
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_d = S_START;
                end
            end
            S_START: if (tx_bit_done) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_state_d = S_DATA;
            end
            S_DATA: if (tx_bit_done) begin
                tx_cnt_d   = '0;
                tx_shreg_d = tx_shreg_q >> 1;
                if (tx_bit_q == BIT_LAST) begin
`ifdef UART_FIFO_PARITY_EN
                    tx_state_d = S_PARITY;
`else
                    tx_state_d = S_STOP;
`endif
                end else begin
                    tx_bit_d = tx_bit_q + 1'b1;
                end
            end
`ifdef UART_FIFO_PARITY_EN
            S_PARITY: if (tx_bit_done) begin
                tx_cnt_d   = '0;
                tx_state_d = S_STOP;
            end
`endif
            S_STOP: if (tx_bit_done) begin
                tx_cnt_d = '0;
                // Chain straight into the next start bit when more data is queued.
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_d = S_START;
                end else begin
                    tx_state_d = S_IDLE;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase

        if (tx_pop) begin
            tx_shreg_d = tx_head;
`ifdef UART_FIFO_PARITY_EN
            tx_par_d   = ^tx_head;
`endif
        end

        case (tx_state_q)
            S_START:    serial_tx_d = 1'b0;
            S_DATA:     serial_tx_d = tx_shreg_q[0];
`ifdef UART_FIFO_PARITY_EN
            S_PARITY:   serial_tx_d = tx_par_q;
`endif
            default:    serial_tx_d = 1'b1;
        endcase
        tx_active_d = (tx_state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shreg_q  <= '0;
            serial_tx_q <= 1'b1;
            tx_active_q <= 1'b0;
`ifdef UART_FIFO_PARITY_EN
            tx_par_q    <= 1'b0;
`endif
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shreg_q  <= tx_shreg_d;
            serial_tx_q <= serial_tx_d;
            tx_active_q <= tx_active_d;
`ifdef UART_FIFO_PARITY_EN
            tx_par_q    <= tx_par_d;
`endif
        end
    end

    assign serial_tx = serial_tx_q;
    assign tx_active = tx_active_q;

    // ---------------- receiver ----------------
    state_t           rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0] rx_bit_q, rx_bit_d;
    logic [1:0]       rx_sync_q, rx_sync_d;
    logic             rx_overrun_q, rx_overrun_d;
    logic             framing_err_q, framing_err_d;
    logic             rx_in;
`ifdef UART_FIFO_PARITY_EN
    logic             rx_par_bad_q, rx_par_bad_d;
    logic             parity_err_q, parity_err_d;
`endif

    always_comb begin
        rx_sync_d     = {rx_sync_q[0], serial_rx};
        rx_in         = rx_sync_q[1];
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q + 1'b1;
        rx_bit_d      = rx_bit_q;
        rx_shreg_d    = rx_shreg_q;
        rx_push       = 1'b0;
        rx_overrun_d  = 1'b0;
        framing_err_d = 1'b0;
`ifdef UART_FIFO_PARITY_EN
        rx_par_bad_d  = rx_par_bad_q;
        parity_err_d  = 1'b0;
`endif
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_in) rx_state_d = S_START;
            end
            // A start bit that is high again at mid-bit is treated as line noise.
            S_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_in ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_cnt_q == CNT_LAST) begin
                rx_cnt_d   = '0;
                rx_shreg_d = {rx_in, rx_shreg_q[DATA_BITS-1:1]};
                if (rx_bit_q == BIT_LAST) begin
`ifdef UART_FIFO_PARITY_EN
                    rx_state_d = S_PARITY;
`else
                    rx_state_d = S_STOP;
`endif
                end else begin
                    rx_bit_d = rx_bit_q + 1'b1;
                end
            end
`ifdef UART_FIFO_PARITY_EN
            S_PARITY: if (rx_cnt_q == CNT_LAST) begin
                rx_cnt_d     = '0;
                rx_par_bad_d = rx_in ^ (^rx_shreg_q);
                rx_state_d   = S_STOP;
            end
`endif
            S_STOP: if (rx_cnt_q == CNT_LAST) begin
                rx_cnt_d   = '0;
                rx_state_d = S_IDLE;
                if (rx_in) begin
                    rx_push      = 1'b1;
                    rx_overrun_d = rx_full && !rx_pop;
                end else begin
                    framing_err_d = 1'b1;
                end
`ifdef UART_FIFO_PARITY_EN
                parity_err_d = rx_par_bad_q;
`endif
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state_q    <= S_IDLE;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_shreg_q    <= '0;
            rx_sync_q     <= 2'b11;
            rx_overrun_q  <= 1'b0;
            framing_err_q <= 1'b0;
`ifdef UART_FIFO_PARITY_EN
            rx_par_bad_q  <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_bit_q      <= rx_bit_d;
            rx_shreg_q    <= rx_shreg_d;
            rx_sync_q     <= rx_sync_d;
            rx_overrun_q  <= rx_overrun_d;
            framing_err_q <= framing_err_d;
`ifdef UART_FIFO_PARITY_EN
            rx_par_bad_q  <= rx_par_bad_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign rx_overrun  = rx_overrun_q;
    assign framing_err = framing_err_q;
`ifdef UART_FIFO_PARITY_EN
    assign parity_err  = parity_err_q;
`endif
endmodule
